// File: rtl/procesador_pkg.sv
// Shared definitions for the processor pipeline control slice.
// Holds the branch opcode, the zero-register index, the control FSM state
// enumeration and a saturating increment helper used by the wait counter.
package procesador_pkg;

  localparam logic [3:0] OP_BRANCH = 4'b1110;
  localparam logic [3:0] REG_ZERO  = 4'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  localparam logic [7:0] CNT8_MAX = 8'hFF;

  // Increment an 8-bit count, sticking at the all-ones value
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    if (value == CNT8_MAX) begin
      return value;
    end
    return value + 8'd1;
  endfunction

endpackage

// File: rtl/detector_riesgos.sv
// Load-use hazard detector.
// Flags a hazard when the instruction in execute is a load whose destination
// (other than the zero register) matches either source register in decode.
import procesador_pkg::*;

module detector_riesgos (
  input  logic       memRead_E,
  input  logic [3:0] rd_E,
  input  logic [3:0] rs1_D,
  input  logic [3:0] rs2_D,
  output logic       hazard
);

  // Pure combinational compare; writes to the zero register never forward
  always_comb begin
    hazard = memRead_E && (rd_E != REG_ZERO) &&
             ((rd_E == rs1_D) || (rd_E == rs2_D));
  end

endmodule

// File: rtl/control_pipeline.sv
// Pipeline control unit: branch redirect, load-use bubble and memory wait.
// Outputs are combinational from the registered state and current inputs,
// so a taken branch redirects in the same cycle it is seen in execute.
// Optional performance counters (flush_cnt, stall_cnt) are built when the
// macro CONTROL_PIPELINE_PERF_EN is defined.
import procesador_pkg::*;

module control_pipeline #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode_E,
  input  logic        cmpFlag,
  input  logic        memRead_E,
  input  logic [3:0]  rd_E,
  input  logic [3:0]  rs1_D,
  input  logic [3:0]  rs2_D,
  input  logic        memReq_M,
  input  logic        mem_ready,
  output logic        pc_Mux,
  output logic        PC_EN,
  output logic        stage_en,
  output logic        NOP_Mux_F,
  output logic        NOP_Mux,
  output logic        NOP_Mux_E,
  output logic [1:0]  state_o,
  output logic        mem_timeout
`ifdef CONTROL_PIPELINE_PERF_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_BUBBLE   = BUBBLE;
  localparam logic [1:0] S_WAIT_MEM = WAIT_MEM;
  localparam logic [7:0] TIMEOUT_LIM = MEM_TIMEOUT[7:0];

  logic [1:0] r_state;
  logic [7:0] r_waitCnt;
  logic       r_timeout;

  logic [1:0] w_stateNext;
  logic [7:0] w_waitCntNext;
  logic [7:0] w_waitCntInc;
  logic       w_timeoutSet;
  logic       w_taken;
  logic       w_hazard;
  logic       w_memStall;

  detector_riesgos u_detector (
    .memRead_E (memRead_E),
    .rd_E      (rd_E),
    .rs1_D     (rs1_D),
    .rs2_D     (rs2_D),
    .hazard    (w_hazard)
  );

  // Branch resolution and memory-stall request decoded from execute/memory
  always_comb begin
    w_taken      = (opcode_E == OP_BRANCH) && cmpFlag;
    w_memStall   = memReq_M && !mem_ready;
    w_waitCntInc = satInc8(r_waitCnt);
  end

  // Next-state and control output decode; reset overrides to the safe squash
  always_comb begin
    pc_Mux        = 1'b0;
    PC_EN         = 1'b1;
    stage_en      = 1'b1;
    NOP_Mux_F     = 1'b0;
    NOP_Mux       = 1'b0;
    NOP_Mux_E     = 1'b0;
    w_stateNext   = S_RUN;
    w_waitCntNext = r_waitCnt;
    w_timeoutSet  = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_memStall) begin
          PC_EN         = 1'b0;
          stage_en      = 1'b0;
          w_waitCntNext = 8'd0;
          w_stateNext   = S_WAIT_MEM;
        end else if (w_taken) begin
          pc_Mux    = 1'b1;
          NOP_Mux_F = 1'b1;
          NOP_Mux   = 1'b1;
        end else if (w_hazard) begin
          PC_EN       = 1'b0;
          stage_en    = 1'b0;
          NOP_Mux_E   = 1'b1;
          w_stateNext = S_BUBBLE;
        end
      end
      S_BUBBLE: begin
        w_stateNext = S_RUN;
      end
      S_WAIT_MEM: begin
        PC_EN    = 1'b0;
        stage_en = 1'b0;
        if (mem_ready) begin
          w_stateNext = S_RUN;
        end else begin
          w_waitCntNext = w_waitCntInc;
          if (w_waitCntInc == TIMEOUT_LIM) begin
            w_timeoutSet = 1'b1;
            w_stateNext  = S_RUN;
          end else begin
            w_stateNext = S_WAIT_MEM;
          end
        end
      end
      default: begin
        w_stateNext = S_RUN;
      end
    endcase

    if (rst) begin
      pc_Mux    = 1'b0;
      PC_EN     = 1'b0;
      stage_en  = 1'b0;
      NOP_Mux_F = 1'b1;
      NOP_Mux   = 1'b1;
      NOP_Mux_E = 1'b1;
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_waitCnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
      r_timeout <= r_timeout | w_timeoutSet;
    end
  end

  assign state_o     = r_state;
  assign mem_timeout = r_timeout;

`ifdef CONTROL_PIPELINE_PERF_EN
  logic [15:0] r_flushCnt;
  logic [15:0] r_stallCnt;

  // Count taken redirects and PC-frozen cycles, both saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flushCnt <= 16'd0;
      r_stallCnt <= 16'd0;
    end else begin
      if (pc_Mux && (r_flushCnt != 16'hFFFF)) begin
        r_flushCnt <= r_flushCnt + 16'd1;
      end
      if (!PC_EN && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 16'd1;
      end
    end
  end

  assign flush_cnt = r_flushCnt;
  assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline.
// Vectors carry inputs plus the expected output bundle
// {state_o, pc_Mux, PC_EN, stage_en, NOP_Mux_F, NOP_Mux, NOP_Mux_E, mem_timeout};
// expectations are queued when a vector is driven and popped at the sample.
module tb_control_pipeline;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       cmp;
    logic       mr;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       mq;
    logic       rdy;
    logic [8:0] exp;
    int         id;
  } vec_t;

  localparam logic [8:0] E_NORM  = 9'b00_011_000_0;
  localparam logic [8:0] E_REDIR = 9'b00_111_110_0;
  localparam logic [8:0] E_HAZ   = 9'b00_000_001_0;
  localparam logic [8:0] E_BUB   = 9'b01_011_000_0;
  localparam logic [8:0] E_MSTL  = 9'b00_000_000_0;
  localparam logic [8:0] E_WAIT  = 9'b10_000_000_0;
  localparam logic [8:0] E_RST   = 9'b00_000_111_0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode_E;
  logic       cmpFlag;
  logic       memRead_E;
  logic [3:0] rd_E;
  logic [3:0] rs1_D;
  logic [3:0] rs2_D;
  logic       memReq_M;
  logic       mem_ready;
  logic       memReq2;
  logic       memReady2;

  logic       pc_Mux, PC_EN, stage_en, NOP_Mux_F, NOP_Mux, NOP_Mux_E, mem_timeout;
  logic [1:0] state_o;
  logic       pc_Mux2, PC_EN2, stage_en2, NOP_Mux_F2, NOP_Mux2, NOP_Mux_E2, mem_timeout2;
  logic [1:0] state_o2;
`ifdef CONTROL_PIPELINE_PERF_EN
  logic [15:0] flush_cnt, stall_cnt, flush_cnt2, stall_cnt2;
`endif

  int nVectors = 0;
  int nMiss = 0;
  vec_t table_q[$];
  vec_t score_q[$];

  always #5 clk = ~clk;

  control_pipeline dut (
    .clk(clk), .rst(rst), .opcode_E(opcode_E), .cmpFlag(cmpFlag),
    .memRead_E(memRead_E), .rd_E(rd_E), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .memReq_M(memReq_M), .mem_ready(mem_ready),
    .pc_Mux(pc_Mux), .PC_EN(PC_EN), .stage_en(stage_en),
    .NOP_Mux_F(NOP_Mux_F), .NOP_Mux(NOP_Mux), .NOP_Mux_E(NOP_Mux_E),
    .state_o(state_o), .mem_timeout(mem_timeout)
`ifdef CONTROL_PIPELINE_PERF_EN
    , .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
  );

  control_pipeline #(.MEM_TIMEOUT(4)) dutTo (
    .clk(clk), .rst(rst), .opcode_E(opcode_E), .cmpFlag(cmpFlag),
    .memRead_E(memRead_E), .rd_E(rd_E), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .memReq_M(memReq2), .mem_ready(memReady2),
    .pc_Mux(pc_Mux2), .PC_EN(PC_EN2), .stage_en(stage_en2),
    .NOP_Mux_F(NOP_Mux_F2), .NOP_Mux(NOP_Mux2), .NOP_Mux_E(NOP_Mux_E2),
    .state_o(state_o2), .mem_timeout(mem_timeout2)
`ifdef CONTROL_PIPELINE_PERF_EN
    , .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2)
`endif
  );

  function automatic vec_t mk(input int id, input logic r, input logic [3:0] op,
                              input logic cmp, input logic mr, input logic [3:0] rd,
                              input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic mq, input logic rdy, input logic [8:0] exp);
    vec_t v;
    v.id = id; v.rst = r; v.op = op; v.cmp = cmp; v.mr = mr; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.mq = mq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  // Drive one vector just after the rising edge and queue its expectation
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; opcode_E = v.op; cmpFlag = v.cmp; memRead_E = v.mr;
    rd_E = v.rd; rs1_D = v.rs1; rs2_D = v.rs2; memReq_M = v.mq; mem_ready = v.rdy;
    score_q.push_back(v);
  endtask

  // Sample on the falling edge and compare against the oldest expectation
  task automatic checkOutput();
    vec_t e;
    logic [8:0] act;
    @(negedge clk);
    act = {state_o, pc_Mux, PC_EN, stage_en, NOP_Mux_F, NOP_Mux, NOP_Mux_E, mem_timeout};
    nVectors++;
    if (score_q.size() == 0) begin
      nMiss++;
      $display("[TB] FAIL scoreboard-empty actual=%b", act);
    end else begin
      e = score_q.pop_front();
      if (act !== e.exp) begin
        nMiss++;
        $display("[TB] FAIL step%0d actual=%b required=%b", e.id, act, e.exp);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [8:0] act, input logic [8:0] req);
    nVectors++;
    if (act !== req) begin
      nMiss++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    int waitCycles;
    int stallCycles;
    bit seenTo;

    rst = 1'b1; opcode_E = 4'd0; cmpFlag = 1'b0; memRead_E = 1'b0; rd_E = 4'd0;
    rs1_D = 4'd0; rs2_D = 4'd0; memReq_M = 1'b0; mem_ready = 1'b0;
    memReq2 = 1'b0; memReady2 = 1'b0;

    table_q.push_back(mk( 1, 1, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_RST));
    table_q.push_back(mk( 2, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk( 3, 0, 4'hE, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_REDIR));
    table_q.push_back(mk( 4, 0, 4'hE, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk( 5, 0, 4'h5, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk( 6, 0, 4'h0, 0, 1, 4'd3, 4'd1, 4'd3, 0, 0, E_HAZ));
    table_q.push_back(mk( 7, 0, 4'h0, 0, 1, 4'd3, 4'd1, 4'd3, 0, 0, E_BUB));
    table_q.push_back(mk( 8, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk( 9, 0, 4'h0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk(10, 0, 4'h0, 0, 1, 4'd7, 4'd7, 4'd2, 0, 0, E_HAZ));
    table_q.push_back(mk(11, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_BUB));
    table_q.push_back(mk(12, 0, 4'h0, 0, 0, 4'd7, 4'd7, 4'd2, 0, 0, E_NORM));
    table_q.push_back(mk(13, 0, 4'hE, 1, 1, 4'd3, 4'd1, 4'd3, 0, 0, E_REDIR));
    table_q.push_back(mk(14, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    table_q.push_back(mk(15, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, E_NORM));
    table_q.push_back(mk(16, 0, 4'hE, 1, 0, 4'd0, 4'd0, 4'd0, 1, 0, E_MSTL));
    table_q.push_back(mk(17, 0, 4'hE, 1, 0, 4'd0, 4'd0, 4'd0, 1, 0, E_WAIT));
    table_q.push_back(mk(18, 0, 4'hE, 1, 0, 4'd0, 4'd0, 4'd0, 1, 1, E_WAIT));
    table_q.push_back(mk(19, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));

    foreach (table_q[i]) begin
      run(table_q[i]);
    end

    // Memory wait with mem_ready low for five cycles: six frozen cycles
    stallCycles = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(mk(30 + c, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 1, (c == 5),
                       (c == 0) ? E_MSTL : E_WAIT));
      checkOutput();
      if (!PC_EN) stallCycles++;
    end
    run(mk(36, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    checkValue("stall-cycles", 9'(stallCycles), 9'd6);

    // Reset in the middle of a memory wait, then clean RUN after release
    run(mk(40, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0, E_MSTL));
    run(mk(41, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0, E_WAIT));
    run(mk(42, 1, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 0, E_RST));
    run(mk(43, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));
    run(mk(44, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));

    // Reset in the middle of a bubble
    run(mk(50, 0, 4'h0, 0, 1, 4'd5, 4'd5, 4'd0, 0, 0, E_HAZ));
    run(mk(51, 1, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_RST));
    run(mk(52, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NORM));

    // Timeout instance: memory never answers, MEM_TIMEOUT=4
    @(posedge clk);
    #1;
    memReq2 = 1'b1; memReady2 = 1'b0;
    waitCycles = 0;
    seenTo = 1'b0;
    for (int c = 0; c < 20 && !seenTo; c++) begin
      @(negedge clk);
      if (mem_timeout2) seenTo = 1'b1;
      else if (state_o2 == 2'd2) waitCycles++;
    end
    checkValue("timeout-seen", {8'd0, seenTo}, 9'd1);
    checkValue("timeout-wait-cycles", 9'(waitCycles), 9'd4);
    checkValue("timeout-state", {7'd0, state_o2}, 9'd0);
    #1;
    memReq2 = 1'b0;
    @(negedge clk);
    checkValue("timeout-sticky", {7'd0, state_o2, mem_timeout2}, 9'b001);
    checkValue("timeout-run-outputs",
               {3'd0, pc_Mux2, PC_EN2, stage_en2, NOP_Mux_F2, NOP_Mux2, NOP_Mux_E2},
               9'b000_011_000);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of consecutive WAIT_MEM cycles (1..255) before timeout.
REQ-002 SHALL have ports: clk  in  1  system clock.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: opcode_E  in  4  opcode of the instruction in execute.
REQ-005 SHALL have ports: cmpFlag  in  1  compare result for the instruction in execute.
REQ-006 SHALL have ports: memRead_E  in  1  the instruction in execute is a load.
REQ-007 SHALL have ports: rd_E  in  4  destination register in execute.
REQ-008 SHALL have ports: rs1_D, rs2_D  in  4 each  source registers in decode.
REQ-009 SHALL have ports: memReq_M  in  1  memory access pending in the memory stage.
REQ-010 SHALL have ports: mem_ready  in  1  memory completes the access this cycle.
REQ-011 SHALL have ports: pc_Mux  out  1  select branch target.
REQ-012 SHALL have ports: PC_EN  out  1  PC update enable, 1 means update.
REQ-013 SHALL have ports: stage_en  out  1  enables the IF/ID and ID/EX registers.
REQ-014 SHALL have ports: NOP_Mux_F, NOP_Mux, NOP_Mux_E  out  1 each  squash fetch, squash decode, and insert a bubble into execute.
REQ-015 SHALL have ports: state_o  out  2  current FSM state.
REQ-016 SHALL have ports: mem_timeout  out  1  sticky timeout error.

Function
REQ-017 SHALL implement FSM states RUN=0, BUBBLE=1, WAIT_MEM=2, with encoding 3 unreachable and recovering to RUN.
REQ-018 SHALL define taken = (opcode_E==OP_BRANCH) && cmpFlag, and hazard = memRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
REQ-019 SHALL give priority in RUN as: memReq_M && !mem_ready > taken > hazard > normal.
REQ-020 In RUN with memReq_M && !mem_ready: SHALL drive PC_EN=0, stage_en=0, and all NOPs=0, then go to WAIT_MEM.
REQ-021 In RUN with taken: SHALL drive pc_Mux=1, PC_EN=1, stage_en=1, NOP_Mux_F=1, and NOP_Mux=1 in the same cycle (combinational, zero latency), then stay in RUN.
REQ-022 In RUN with hazard and not taken: SHALL drive PC_EN=0, stage_en=0, and NOP_Mux_E=1, then go to BUBBLE.
REQ-023 In BUBBLE: SHALL drive all outputs to normal values (PC_EN=1, stage_en=1, NOPs=0), then return to RUN unconditionally; there is no back-to-back bubble for the same hazard.
REQ-024 In WAIT_MEM: SHALL hold PC_EN=0 and stage_en=0, keep pc_Mux=0 regardless of taken, and return to RUN in the cycle after mem_ready=1.
REQ-025 SHALL keep a WAIT_MEM cycle counter of 8 bits that clears on WAIT_MEM entry and increments saturating at 255.
REQ-026 SHALL set mem_timeout on the counter reaching MEM_TIMEOUT, hold it until rst, and force the FSM to RUN.
REQ-027 In the normal case: SHALL drive pc_Mux=0, PC_EN=1, stage_en=1, and all NOPs=0.
REQ-028 SHALL drive state_o as the registered state.

Reset
REQ-029 While rst=1: SHALL hold state=RUN, counter=0, mem_timeout=0, pc_Mux=0, PC_EN=0, stage_en=0, and NOP_Mux_F=NOP_Mux=NOP_Mux_E=1.
REQ-030 Reset asserted mid-WAIT_MEM or mid-BUBBLE SHALL abort immediately with no residual stall after release.
REQ-031 The first cycle after rst deasserts SHALL evaluate RUN rules.

Configuration
REQ-032 SHALL provide macro CONTROL_PIPELINE_PERF_EN which, when defined, adds outputs flush_cnt and stall_cnt (16 bits each, saturating at 0xFFFF, cleared by rst).
REQ-033 With CONTROL_PIPELINE_PERF_EN: flush_cnt SHALL increment per taken redirect, and stall_cnt SHALL increment per cycle with PC_EN=0 outside reset.
REQ-034 Without CONTROL_PIPELINE_PERF_EN: SHALL have no counters, ports or registers.

Structure
REQ-035 Package procesador_pkg SHALL hold OP_BRANCH=4'b1110, the state enum (RUN/BUBBLE/WAIT_MEM), and REG_ZERO=4'd0.
REQ-036 The hazard compare SHALL be a sub-module detector_riesgos (pure combinational, outputs hazard); the taken logic stays local.

Verification
REQ-037 The bench SHALL cover: opcode_E=1110, cmpFlag=1 in RUN -> same cycle pc_Mux=1, NOP_Mux_F=1, NOP_Mux=1, state stays RUN.
REQ-038 The bench SHALL cover: memRead_E=1, rd_E=3, rs2_D=3 -> one cycle PC_EN=0 and NOP_Mux_E=1, next cycle BUBBLE with normal outputs, then RUN.
REQ-039 The bench SHALL cover: memRead_E=1 with rd_E=0 and rs1_D=0 -> no stall.
REQ-040 The bench SHALL cover: taken and hazard in the same cycle -> redirect only, NOP_Mux_E=0, state RUN.
REQ-041 The bench SHALL cover: memReq_M=1 with mem_ready low for 5 cycles -> PC_EN=0 for 6 cycles, RUN on the cycle after mem_ready; with MEM_TIMEOUT=4 and mem_ready never asserted -> mem_timeout=1 and RUN.
REQ-042 The bench SHALL cover: rst asserted in WAIT_MEM -> immediate reset outputs (PC_EN=0, NOPs=1), and RUN normal outputs the cycle after release.
